// File: rtl/rtc_display_scheduler_pkg.sv
// Shared constants for the RTC display scheduler: register map, sweep order
// and FSM state encoding.
package rtc_display_scheduler_pkg;

    localparam logic [7:0] ADDR_SEG    = 8'h21;
    localparam logic [7:0] ADDR_MIN    = 8'h22;
    localparam logic [7:0] ADDR_HORA   = 8'h23;
    localparam logic [7:0] ADDR_DIA    = 8'h24;
    localparam logic [7:0] ADDR_MES    = 8'h25;
    localparam logic [7:0] ADDR_ANO    = 8'h26;
    localparam logic [7:0] ADDR_SEGT   = 8'h41;
    localparam logic [7:0] ADDR_MINT   = 8'h42;
    localparam logic [7:0] ADDR_HORAT  = 8'h43;
    localparam logic [7:0] ADDR_STATUS = 8'h00;

    localparam int unsigned NUM_SWEEP = 10;

    typedef logic [3:0] sweep_idx_t;
    localparam sweep_idx_t LAST_IDX = 4'd9;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RD     = 2'd1;
    localparam logic [1:0] ST_WR     = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    function automatic logic [7:0] sweep_addr(input sweep_idx_t idx);
        logic [7:0] a;
        case (idx)
            4'd0:    a = ADDR_SEG;
            4'd1:    a = ADDR_MIN;
            4'd2:    a = ADDR_HORA;
            4'd3:    a = ADDR_DIA;
            4'd4:    a = ADDR_MES;
            4'd5:    a = ADDR_ANO;
            4'd6:    a = ADDR_SEGT;
            4'd7:    a = ADDR_MINT;
            4'd8:    a = ADDR_HORAT;
            default: a = ADDR_STATUS;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/rtc_display_scheduler_if.sv
// RTC bus between the display scheduler (master) and the bus driver (slave).
interface rtc_display_scheduler_if;

    logic       bus_req;
    logic       bus_wr;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_ack;
    logic [7:0] bus_rdata;

    modport master (
        output bus_req, bus_wr, bus_addr, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_wr, bus_addr, bus_wdata,
        output bus_ack, bus_rdata
    );

endinterface

// File: rtl/rtc_display_scheduler_timeout.sv
// Bus watchdog: counts cycles of an outstanding request and pulses on expiry.
module rtc_bus_timeout #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam int unsigned W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Expires in the TIMEOUT-th consecutive unacknowledged request cycle.
    assign expire_o = run_i && !clr_i && (cnt_q == W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!run_i || clr_i || expire_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rtc_display_scheduler.sv
// Arbitrates the RTC bus between the per-frame display sweep and user writes,
// committing swept values atomically to the display shadow registers.
module rtc_display_scheduler
    import rtc_display_scheduler_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned ALARM_BIT = 3
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          frame_start,
    input  logic                          wr_req,
    input  logic [7:0]                    wr_addr,
    input  logic [7:0]                    wr_data,
    output logic                          wr_ack,
    rtc_display_scheduler_if.master       bus,
    output logic [7:0]                    ANO,
    output logic [7:0]                    MES,
    output logic [7:0]                    DIA,
    output logic [7:0]                    HORA,
    output logic [7:0]                    MIN,
    output logic [7:0]                    SEG,
    output logic [7:0]                    HORAT,
    output logic [7:0]                    MINT,
    output logic [7:0]                    SEGT,
    output logic                          ALARMA,
    output logic                          busy,
    output logic                          frame_miss,
    output logic                          bus_err
);

    localparam logic [2:0] ALARM_SEL = ALARM_BIT[2:0];

    logic [1:0] state_q, state_d;
    sweep_idx_t idx_q, idx_d;
    logic       dirty_q, dirty_d;
    logic       pend_q, pend_d;
    logic       susp_q, susp_d;
    logic       gap_q, gap_d;
    logic [7:0] stage_q [NUM_SWEEP];

    logic req_w, ack_v, tmo_expire, stage_we, commit;

    assign req_w = ((state_q == ST_RD) || (state_q == ST_WR)) && !gap_q;
    assign ack_v = req_w && bus.bus_ack;

    assign bus.bus_req   = req_w;
    assign bus.bus_wr    = req_w && (state_q == ST_WR);
    assign bus.bus_addr  = !req_w ? '0 : ((state_q == ST_WR) ? wr_addr : sweep_addr(idx_q));
    assign bus.bus_wdata = (req_w && (state_q == ST_WR)) ? wr_data : '0;

    assign wr_ack     = ack_v && (state_q == ST_WR);
    assign frame_miss = frame_start && (state_q != ST_IDLE);
    assign bus_err    = tmo_expire;
    assign busy       = (state_q != ST_IDLE);

    rtc_bus_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk      (CLK),
        .rst      (RST),
        .run_i    (req_w),
        .clr_i    (bus.bus_ack),
        .expire_o (tmo_expire)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        dirty_d  = dirty_q;
        pend_d   = pend_q;
        susp_d   = susp_q;
        gap_d    = 1'b0;
        stage_we = 1'b0;
        commit   = 1'b0;
        if (tmo_expire) begin
            state_d = ST_IDLE;
            pend_d  = 1'b0;
            susp_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_start) begin
                        idx_d   = '0;
                        dirty_d = 1'b0;
                    end
                    // A simultaneous frame_start is parked as pending behind the write.
                    if (wr_req) begin
                        state_d = ST_WR;
                        pend_d  = frame_start;
                    end else if (frame_start) begin
                        state_d = ST_RD;
                    end
                end
                ST_RD: begin
                    if (ack_v) begin
                        stage_we = 1'b1;
                        gap_d    = 1'b1;
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_COMMIT;
                        end else if (wr_req) begin
                            state_d = ST_WR;
                            susp_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + 4'd1;
                        end
                    end
                end
                ST_WR: begin
                    if (ack_v) begin
                        gap_d = 1'b1;
                        if (susp_q) begin
                            susp_d  = 1'b0;
                            dirty_d = 1'b1;
                            idx_d   = idx_q + 4'd1;
                            state_d = ST_RD;
                        end else if (pend_q) begin
                            pend_d  = 1'b0;
                            state_d = ST_RD;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_COMMIT: begin
                    commit  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            dirty_q <= 1'b0;
            pend_q  <= 1'b0;
            susp_q  <= 1'b0;
            gap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dirty_q <= dirty_d;
            pend_q  <= pend_d;
            susp_q  <= susp_d;
            gap_q   <= gap_d;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < NUM_SWEEP; i++) begin
                stage_q[i] <= '0;
            end
        end else if (stage_we) begin
            stage_q[idx_q] <= bus.bus_rdata;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            SEG    <= '0;
            MIN    <= '0;
            HORA   <= '0;
            DIA    <= '0;
            MES    <= '0;
            ANO    <= '0;
            SEGT   <= '0;
            MINT   <= '0;
            HORAT  <= '0;
            ALARMA <= 1'b0;
        end else if (commit && !dirty_q) begin
            SEG    <= stage_q[0];
            MIN    <= stage_q[1];
            HORA   <= stage_q[2];
            DIA    <= stage_q[3];
            MES    <= stage_q[4];
            ANO    <= stage_q[5];
            SEGT   <= stage_q[6];
            MINT   <= stage_q[7];
            HORAT  <= stage_q[8];
            ALARMA <= stage_q[LAST_IDX][ALARM_SEL];
        end
    end

endmodule
